// File: rtl/order_entry.sv
// order_entry: keypad front end for the ticket vendor.
// Collects the source station, the destination station and the ticket count as
// decimal keypad entries. Each field is range-checked when it is confirmed. The
// completed order is presented on registered outputs, followed one cycle later
// by a single-cycle done pulse.
//
// Ports:
//   i_clk           single clock, all logic on posedge
//   i_rst           synchronous active-high reset, dominates all other inputs
//   i_key_valid     one-cycle strobe, i_key_code valid this cycle
//   i_key_code      0-9 digit, A confirm, B clear field, C cancel order, others ignored
//   i_dispense_busy vendor still dispensing; holds the lock and defers count confirm
//   o_input_src     source station of last accepted order
//   o_input_dest    destination station of last accepted order
//   o_input_count   ticket count of last accepted order
//   o_done          one-cycle pulse, order on o_input_* is complete
//   o_entry_err     one-cycle pulse, confirm rejected
//   o_field_sel     0 src, 1 dest, 2 count, 3 locked
module order_entry #(
  parameter int DW          = 8,
  parameter int MAX_STATION = 15,
  parameter int MAX_COUNT   = 9
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_key_valid,
  input  logic [3:0]    i_key_code,
  input  logic          i_dispense_busy,
  output logic [DW-1:0] o_input_src,
  output logic [DW-1:0] o_input_dest,
  output logic [DW-1:0] o_input_count,
  output logic          o_done,
  output logic          o_entry_err,
  output logic [1:0]    o_field_sel
);

  typedef enum logic [2:0] {
    S_SRC  = 3'd0,
    S_DEST = 3'd1,
    S_CNT  = 3'd2,
    S_DONE = 3'd3,
    S_LOCK = 3'd4
  } state_t;

  localparam logic [6:0] LIM_ST  = 7'(MAX_STATION);
  localparam logic [6:0] LIM_CNT = 7'(MAX_COUNT);

  state_t        r_state;
  logic [6:0]    r_acc;
  logic [1:0]    r_digit_cnt;
  logic [6:0]    r_src_stage;
  logic [6:0]    r_dest_stage;
  logic [DW-1:0] r_src;
  logic [DW-1:0] r_dest;
  logic [DW-1:0] r_count;
  logic          r_done;
  logic          r_err;
  logic [1:0]    r_field_sel;
  logic [1:0]    r_lock_cnt;
  // count confirm seen while the vendor was busy, completes once busy drops
  logic          r_cnf_pend;

  logic       w_digit;
  logic       w_confirm;
  logic       w_clear;
  logic       w_cancel;
  logic [6:0] w_acc_shift;
  logic       w_station_ok;
  logic       w_dest_ok;
  logic       w_count_ok;

  assign w_digit   = i_key_valid && (i_key_code <= 4'd9);
  assign w_confirm = i_key_valid && (i_key_code == 4'hA);
  assign w_clear   = i_key_valid && (i_key_code == 4'hB);
  assign w_cancel  = i_key_valid && (i_key_code == 4'hC);

  // only used while fewer than 2 digits are held, so the result never exceeds 99
  assign w_acc_shift  = (r_acc * 7'd10) + {3'b000, i_key_code};
  assign w_station_ok = (r_acc != 7'd0) && (r_acc <= LIM_ST);
  assign w_dest_ok    = w_station_ok && (r_acc != r_src_stage);
  assign w_count_ok   = (r_acc != 7'd0) && (r_acc <= LIM_CNT);

  // entry FSM with all outputs registered
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_SRC;
      r_acc        <= 7'd0;
      r_digit_cnt  <= 2'd0;
      r_src_stage  <= 7'd0;
      r_dest_stage <= 7'd0;
      r_src        <= {DW{1'b0}};
      r_dest       <= {DW{1'b0}};
      r_count      <= {DW{1'b0}};
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_field_sel  <= 2'd0;
      r_lock_cnt   <= 2'd0;
      r_cnf_pend   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_SRC, S_DEST, S_CNT: begin
          if (w_cancel) begin
            r_acc        <= 7'd0;
            r_digit_cnt  <= 2'd0;
            r_src_stage  <= 7'd0;
            r_dest_stage <= 7'd0;
            r_cnf_pend   <= 1'b0;
            r_state      <= S_SRC;
            r_field_sel  <= 2'd0;
          end else if ((r_state == S_CNT) && (r_cnf_pend || w_confirm)) begin
            // a pending count confirm freezes the field until the vendor is idle
            if (i_dispense_busy) begin
              r_cnf_pend <= 1'b1;
            end else begin
              r_cnf_pend  <= 1'b0;
              r_acc       <= 7'd0;
              r_digit_cnt <= 2'd0;
              if (w_count_ok) begin
                r_src       <= DW'(r_src_stage);
                r_dest      <= DW'(r_dest_stage);
                r_count     <= DW'(r_acc);
                r_state     <= S_DONE;
                r_field_sel <= 2'd3;
              end else begin
                r_err <= 1'b1;
              end
            end
          end else if (w_confirm) begin
            r_acc       <= 7'd0;
            r_digit_cnt <= 2'd0;
            if (r_state == S_SRC) begin
              if (w_station_ok) begin
                r_src_stage <= r_acc;
                r_state     <= S_DEST;
                r_field_sel <= 2'd1;
              end else begin
                r_err <= 1'b1;
              end
            end else begin
              if (w_dest_ok) begin
                r_dest_stage <= r_acc;
                r_state      <= S_CNT;
                r_field_sel  <= 2'd2;
              end else begin
                r_err <= 1'b1;
              end
            end
          end else if (w_clear) begin
            r_acc       <= 7'd0;
            r_digit_cnt <= 2'd0;
          end else if (w_digit && (r_digit_cnt < 2'd2)) begin
            r_acc       <= w_acc_shift;
            r_digit_cnt <= r_digit_cnt + 2'd1;
          end
        end
        S_DONE: begin
          r_done      <= 1'b1;
          r_lock_cnt  <= 2'd0;
          r_state     <= S_LOCK;
          r_field_sel <= 2'd3;
        end
        S_LOCK: begin
          // first lock cycle carries done; busy is only trusted two cycles later
          if (r_lock_cnt < 2'd2) begin
            r_lock_cnt <= r_lock_cnt + 2'd1;
          end else if (!i_dispense_busy) begin
            r_state     <= S_SRC;
            r_field_sel <= 2'd0;
          end
        end
        default: begin
          r_state     <= S_SRC;
          r_field_sel <= 2'd0;
          r_acc       <= 7'd0;
          r_digit_cnt <= 2'd0;
          r_cnf_pend  <= 1'b0;
        end
      endcase
    end
  end

  assign o_input_src   = r_src;
  assign o_input_dest  = r_dest;
  assign o_input_count = r_count;
  assign o_done        = r_done;
  assign o_entry_err   = r_err;
  assign o_field_sel   = r_field_sel;

endmodule

// File: tb/tb_order_entry.sv
module tb_order_entry;

  logic       clk;
  logic       rst;
  logic       key_valid;
  logic [3:0] key_code;
  logic       busy;
  logic [7:0] input_src;
  logic [7:0] input_dest;
  logic [7:0] input_count;
  logic       done;
  logic       entry_err;
  logic [1:0] field_sel;

  order_entry #(.DW(8), .MAX_STATION(15), .MAX_COUNT(9)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_key_valid     (key_valid),
    .i_key_code      (key_code),
    .i_dispense_busy (busy),
    .o_input_src     (input_src),
    .o_input_dest    (input_dest),
    .o_input_count   (input_count),
    .o_done          (done),
    .o_entry_err     (entry_err),
    .o_field_sel     (field_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       kv;
    logic [3:0] code;
    logic       busy;
    logic [1:0] fs;
    logic       done;
    logic       err;
    logic       push;
    logic [7:0] s;
    logic [7:0] d;
    logic [7:0] c;
  } vec_t;

  typedef struct {
    logic [7:0] s;
    logic [7:0] d;
    logic [7:0] c;
  } order_t;

  vec_t   tbl[$];
  order_t sb[$];
  int     n_vec = 0;
  int     n_bad = 0;
  logic [7:0] exp_s, exp_d, exp_c;

  task automatic add(input logic r, input logic kv, input logic [3:0] code, input logic b,
                     input logic [1:0] fs, input logic dn, input logic er, input logic p,
                     input logic [7:0] s, input logic [7:0] d, input logic [7:0] c);
    vec_t v;
    v.rst = r; v.kv = kv; v.code = code; v.busy = b; v.fs = fs; v.done = dn; v.err = er;
    v.push = p; v.s = s; v.d = d; v.c = c;
    tbl.push_back(v);
  endtask

  task automatic k(input logic [3:0] code, input logic b, input logic [1:0] fs, input logic er);
    add(1'b0, 1'b1, code, b, fs, 1'b0, er, 1'b0, 8'd0, 8'd0, 8'd0);
  endtask

  task automatic id(input logic b, input logic [1:0] fs, input logic dn);
    add(1'b0, 1'b0, 4'd0, b, fs, dn, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
  endtask

  task automatic kp(input logic kv, input logic [3:0] code, input logic b,
                    input logic [7:0] s, input logic [7:0] d, input logic [7:0] c);
    add(1'b0, kv, code, b, 2'd3, 1'b0, 1'b0, 1'b1, s, d, c);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1; key_valid = 1'b0; key_code = 4'd0; busy = 1'b0;
    exp_s = 8'd0; exp_d = 8'd0; exp_c = 8'd0;

    // reset
    add(1'b1, 1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    add(1'b1, 1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    // order 3,7,2; vendor busy through the lock, key in lock ignored
    k(4'd3, 1'b0, 2'd0, 1'b0); k(4'hA, 1'b0, 2'd1, 1'b0);
    k(4'd7, 1'b0, 2'd1, 1'b0); k(4'hA, 1'b0, 2'd2, 1'b0);
    k(4'd2, 1'b0, 2'd2, 1'b0); kp(1'b1, 4'hA, 1'b0, 8'd3, 8'd7, 8'd2);
    id(1'b1, 2'd3, 1'b1); id(1'b1, 2'd3, 1'b0); id(1'b1, 2'd3, 1'b0); id(1'b1, 2'd3, 1'b0);
    k(4'd5, 1'b1, 2'd3, 1'b0); id(1'b0, 2'd0, 1'b0);
    // src 16 out of range, then src==dest rejected, then cancel
    k(4'd1, 1'b0, 2'd0, 1'b0); k(4'd6, 1'b0, 2'd0, 1'b0); k(4'hA, 1'b0, 2'd0, 1'b1);
    k(4'd5, 1'b0, 2'd0, 1'b0); k(4'hA, 1'b0, 2'd1, 1'b0);
    k(4'd5, 1'b0, 2'd1, 1'b0); k(4'hA, 1'b0, 2'd1, 1'b1); k(4'hC, 1'b0, 2'd0, 1'b0);
    // third digit ignored (src 12), clear, empty confirm, dest 15 at the limit
    k(4'd1, 1'b0, 2'd0, 1'b0); k(4'd2, 1'b0, 2'd0, 1'b0); k(4'd3, 1'b0, 2'd0, 1'b0);
    k(4'hA, 1'b0, 2'd1, 1'b0); k(4'd4, 1'b0, 2'd1, 1'b0); k(4'hB, 1'b0, 2'd1, 1'b0);
    k(4'hA, 1'b0, 2'd1, 1'b1); k(4'd1, 1'b0, 2'd1, 1'b0); k(4'd5, 1'b0, 2'd1, 1'b0);
    k(4'hA, 1'b0, 2'd2, 1'b0);
    // count 0 and 10 rejected, 9 accepted; vendor idle so lock lasts the minimum
    k(4'd0, 1'b0, 2'd2, 1'b0); k(4'hA, 1'b0, 2'd2, 1'b1);
    k(4'd1, 1'b0, 2'd2, 1'b0); k(4'd0, 1'b0, 2'd2, 1'b0); k(4'hA, 1'b0, 2'd2, 1'b1);
    k(4'd9, 1'b0, 2'd2, 1'b0); kp(1'b1, 4'hA, 1'b0, 8'd12, 8'd15, 8'd9);
    id(1'b0, 2'd3, 1'b1); id(1'b0, 2'd3, 1'b0); id(1'b0, 2'd3, 1'b0); id(1'b0, 2'd0, 1'b0);
    // ignored code, then cancel mid-order keeps the previous order
    k(4'hF, 1'b0, 2'd0, 1'b0); k(4'd2, 1'b0, 2'd0, 1'b0); k(4'hA, 1'b0, 2'd1, 1'b0);
    k(4'hC, 1'b0, 2'd0, 1'b0); id(1'b0, 2'd0, 1'b0);
    // entry while busy; count confirm deferred until busy drops
    k(4'd1, 1'b1, 2'd0, 1'b0); k(4'hA, 1'b1, 2'd1, 1'b0);
    k(4'd2, 1'b1, 2'd1, 1'b0); k(4'hA, 1'b1, 2'd2, 1'b0);
    k(4'd3, 1'b1, 2'd2, 1'b0); k(4'hA, 1'b1, 2'd2, 1'b0); id(1'b1, 2'd2, 1'b0);
    kp(1'b0, 4'd0, 1'b0, 8'd1, 8'd2, 8'd3);
    id(1'b1, 2'd3, 1'b1); k(4'hC, 1'b1, 2'd3, 1'b0); k(4'hA, 1'b1, 2'd3, 1'b0);
    k(4'd5, 1'b1, 2'd3, 1'b0); id(1'b0, 2'd0, 1'b0);
    // reset mid-entry with a simultaneous confirm key
    k(4'd1, 1'b0, 2'd0, 1'b0); k(4'd2, 1'b0, 2'd0, 1'b0); k(4'hA, 1'b0, 2'd1, 1'b0);
    k(4'd3, 1'b0, 2'd1, 1'b0);
    add(1'b1, 1'b1, 4'hA, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    k(4'hA, 1'b0, 2'd0, 1'b1); k(4'd4, 1'b0, 2'd0, 1'b0); k(4'hA, 1'b0, 2'd1, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      rst       = tbl[i].rst;
      key_valid = tbl[i].kv;
      key_code  = tbl[i].code;
      busy      = tbl[i].busy;
      if (tbl[i].rst) begin
        exp_s = 8'd0; exp_d = 8'd0; exp_c = 8'd0;
        sb.delete();
      end
      if (tbl[i].push) begin
        order_t o;
        o.s = tbl[i].s; o.d = tbl[i].d; o.c = tbl[i].c;
        sb.push_back(o);
        exp_s = tbl[i].s; exp_d = tbl[i].d; exp_c = tbl[i].c;
      end
      @(posedge clk);
      #1;
      check("field_sel", i, {30'd0, field_sel}, {30'd0, tbl[i].fs});
      check("done", i, {31'd0, done}, {31'd0, tbl[i].done});
      check("entry_err", i, {31'd0, entry_err}, {31'd0, tbl[i].err});
      check("inputs", i, {8'd0, input_src, input_dest, input_count}, {8'd0, exp_s, exp_d, exp_c});
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          check("done_unexpected", i, 32'd1, 32'd0);
        end else begin
          order_t o;
          o = sb.pop_front();
          check("order", i, {8'd0, input_src, input_dest, input_count}, {8'd0, o.s, o.d, o.c});
        end
      end
    end
    key_valid = 1'b0;
    check("sb_empty", tbl.size(), sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
